// File: rtl/dma_mrd_splitter.sv
// Splits one host DMA read command into PCIe MRd requests that never cross a
// 4 KB boundary, drawing tags from a small pool and tracking completions per tag.
module dma_mrd_splitter #(
    parameter int         C_PCIE_ADDR_WIDTH = 48,
    parameter int         C_MAX_RD_DW       = 128,
    parameter logic [7:0] C_TAG_BASE        = 8'h00,
    parameter int         C_TAG_NUM         = 4
) (
    input  logic                         pcie_user_clk,
    input  logic                         pcie_user_rst_n,
    input  logic                         dma_rd_req,
    input  logic [C_PCIE_ADDR_WIDTH-1:2] dma_rd_addr,
    input  logic [15:0]                  dma_rd_len,
    output logic                         dma_rd_req_ack,
    output logic                         dma_rd_done,
    output logic                         busy,
    output logic                         tx_mrd_req,
    output logic [7:0]                   tx_mrd_tag,
    output logic [12:2]                  tx_mrd_len,
    output logic [C_PCIE_ADDR_WIDTH-1:2] tx_mrd_addr,
    input  logic                         tx_mrd_req_ack,
    input  logic                         cpld_fifo_wr_en,
    input  logic [7:0]                   cpld_fifo_tag,
    input  logic                         cpld_fifo_tag_last,
    output logic                         cpld_tag_err
);

    localparam int         AW_DW     = C_PCIE_ADDR_WIDTH - 2;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CALC    = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    // The busy vector is always 8 wide; bits above the pool size stay zero.
    localparam logic [7:0] POOL_MASK = 8'hFF >> (8 - C_TAG_NUM);
    localparam logic [10:0] MAX_RD   = 11'(C_MAX_RD_DW);

    function automatic logic [10:0] min_chunk(input logic [15:0] rem,
                                              input logic [10:0] max_rd,
                                              input logic [10:0] bnd);
        logic [10:0] c;
        c = (rem > {5'd0, max_rd}) ? max_rd : rem[10:0];
        min_chunk = (c > bnd) ? bnd : c;
    endfunction

    logic [2:0]                   state_r;
    logic [C_PCIE_ADDR_WIDTH-1:2] addr_r;
    logic [15:0]                  remaining_r;
    logic [10:0]                  chunk_r;
    logic [7:0]                   tag_busy_r;
    logic [2:0]                   tag_idx_r;
    logic                         ack_r;
    logic                         done_r;
    logic                         busy_r;
    logic                         tx_req_r;
    logic [7:0]                   tx_tag_r;
    logic [10:0]                  tx_len_r;
    logic [C_PCIE_ADDR_WIDTH-1:2] tx_addr_r;
    logic                         tag_err_r;

    logic [10:0] bnd_s;
    logic [10:0] chunk_s;
    logic        any_free_s;
    logic [2:0]  free_idx_s;
    logic [7:0]  tag_off_s;
    logic        in_pool_s;
    logic        cpl_hit_s;
    logic        cpl_free_s;
    logic        cpl_err_s;
    logic [7:0]  free_mask_s;
    logic [7:0]  alloc_mask_s;
    logic        mrd_accept_s;
    logic [15:0] rem_next_s;

    // Chunk sizing, free-tag search and completion classification.
    always_comb begin
        bnd_s      = 11'd1024 - {1'b0, addr_r[11:2]};
        chunk_s    = min_chunk(remaining_r, MAX_RD, bnd_s);
        any_free_s = |(~tag_busy_r & POOL_MASK);
        free_idx_s = 3'd0;
        // Descending scan so the lowest free index is the one that sticks.
        for (int i = 7; i >= 0; i--) begin
            if (POOL_MASK[i] && !tag_busy_r[i]) begin
                free_idx_s = 3'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
        tag_off_s    = cpld_fifo_tag - C_TAG_BASE;
        in_pool_s    = (tag_off_s < 8'(C_TAG_NUM));
        cpl_hit_s    = in_pool_s && tag_busy_r[tag_off_s[2:0]];
        cpl_free_s   = cpld_fifo_wr_en && cpld_fifo_tag_last && cpl_hit_s;
        cpl_err_s    = cpld_fifo_wr_en && !cpl_hit_s;
        free_mask_s  = cpl_free_s ? (8'd1 << tag_off_s[2:0]) : 8'd0;
        mrd_accept_s = (state_r == S_REQ) && tx_req_r && tx_mrd_req_ack;
        alloc_mask_s = mrd_accept_s ? (8'd1 << tag_idx_r) : 8'd0;
        rem_next_s   = remaining_r - {5'd0, chunk_r};
    end

    // Tag pool bookkeeping; a free and an allocation on one edge never collide.
    always_ff @(posedge pcie_user_clk) begin
        if (!pcie_user_rst_n) begin
            tag_busy_r <= 8'd0;
            tag_err_r  <= 1'b0;
        end else begin
            tag_busy_r <= (tag_busy_r & ~free_mask_s) | alloc_mask_s;
            tag_err_r  <= cpl_err_s;
        end
    end

    // Command FSM and registered request/handshake outputs.
    always_ff @(posedge pcie_user_clk) begin
        if (!pcie_user_rst_n) begin
            state_r     <= S_IDLE;
            addr_r      <= '0;
            remaining_r <= 16'd0;
            chunk_r     <= 11'd0;
            tag_idx_r   <= 3'd0;
            ack_r       <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            tx_req_r    <= 1'b0;
            tx_tag_r    <= 8'd0;
            tx_len_r    <= 11'd0;
            tx_addr_r   <= '0;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (dma_rd_req) begin
                        addr_r      <= dma_rd_addr;
                        remaining_r <= dma_rd_len;
                        ack_r       <= 1'b1;
                        busy_r      <= 1'b1;
                        if (dma_rd_len == 16'd0) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    chunk_r <= chunk_s;
                    if (any_free_s) begin
                        state_r <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!tx_req_r) begin
                        tx_req_r  <= 1'b1;
                        tag_idx_r <= free_idx_s;
                        tx_tag_r  <= C_TAG_BASE + {5'd0, free_idx_s};
                        tx_len_r  <= chunk_r;
                        tx_addr_r <= addr_r;
                    end else if (tx_mrd_req_ack) begin
                        tx_req_r    <= 1'b0;
                        addr_r      <= addr_r + AW_DW'(chunk_r);
                        remaining_r <= rem_next_s;
                        state_r     <= (rem_next_s != 16'd0) ? S_CALC : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((tag_busy_r & POOL_MASK) == 8'd0) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign dma_rd_req_ack = ack_r;
    assign dma_rd_done    = done_r;
    assign busy           = busy_r;
    assign tx_mrd_req     = tx_req_r;
    assign tx_mrd_tag     = tx_tag_r;
    assign tx_mrd_len     = tx_len_r;
    assign tx_mrd_addr    = tx_addr_r;
    assign cpld_tag_err   = tag_err_r;

endmodule
